// File: rtl/pix_bus_tx_if.sv
// PIX transmit bus bundle: frame queue handshake, wire outputs and status.
interface pix_bus_tx_if #(
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_frame;
   logic          phi2;
   logic [3:0]    pix;
   logic          busy;
   logic          frame_start;
   logic [CW-1:0] fifo_count;

   modport master (
      output in_valid, in_frame,
      input  in_ready, phi2, pix, busy, frame_start, fifo_count
   );

   modport slave (
      input  in_valid, in_frame,
      output in_ready, phi2, pix, busy, frame_start, fifo_count
   );
endinterface

// File: rtl/pix_bus_tx.sv
// PIX bus transmitter: queues 32-bit frames and sends each as 8 DDR nibbles
// over 4 phi2 periods, with pix launched mid-half so it is centred on phi2 edges.
module pix_bus_tx #(
   parameter int unsigned DIV        = 2,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned GAP        = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   pix_bus_tx_if.slave   bus
);
   localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned GW      = (GAP > 1) ? $clog2(GAP) : 1;
   localparam bit          HAS_GAP = (GAP != 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   logic [DW-1:0] div_cnt;
   logic          phi2_q;
   state_t        state, state_n;
   logic [27:0]   shifter, shifter_n;
   logic [2:0]    nib, nib_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [3:0]    pix_q, pix_n;
   logic          fs_q, fs_n;
   logic          busy_q;
   logic          in_ready_q;
   logic [CW-1:0] count, count_n;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [31:0]   load_frame;
   logic          edge_tick, mid_tick, high_mid;
   logic          push, pop, start, fifo_empty;

   assign edge_tick  = (div_cnt == DW'(DIV - 1));
   assign mid_tick   = (div_cnt == DW'(DIV / 2 - 1));
   assign high_mid   = mid_tick && phi2_q;
   assign fifo_empty = (count == '0);
   assign push       = bus.in_valid && in_ready_q;
   // Framing bit is forced on the wire regardless of what was queued.
   assign load_frame = mem[rd_ptr] | 32'h1000_0000;

   // phi2 generator, free-running out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         phi2_q  <= 1'b1;
      end else begin
         div_cnt <= edge_tick ? '0 : div_cnt + DW'(1);
         if (edge_tick) phi2_q <= ~phi2_q;
      end
   end

   // Frame queue storage
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_frame;
   end

   always_comb begin
      count_n = count;
      if (push && !pop)      count_n = count + CW'(1);
      else if (pop && !push) count_n = count - CW'(1);
   end

   // in_ready follows the registered count, so a pop never frees a slot the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count      <= count_n;
         in_ready_q <= (count_n < CW'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shifter <= '0;
         nib     <= '0;
         gap_cnt <= '0;
         pix_q   <= 4'h0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         shifter <= shifter_n;
         nib     <= nib_n;
         gap_cnt <= gap_n;
         pix_q   <= pix_n;
         fs_q    <= fs_n;
         busy_q  <= (state_n != ST_IDLE) || (count_n != '0);
      end
   end

   // Frame sequencing; new frames only ever start on a high-half mid tick
   always_comb begin
      state_n   = state;
      shifter_n = shifter;
      nib_n     = nib;
      gap_n     = gap_cnt;
      pix_n     = pix_q;
      fs_n      = 1'b0;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            pix_n = 4'h0;
            if (high_mid && !fifo_empty) start = 1'b1;
         end
         ST_SEND: begin
            if (mid_tick) begin
               if (nib != 3'd7) begin
                  pix_n     = shifter[27:24];
                  shifter_n = {shifter[23:0], 4'h0};
                  nib_n     = nib + 3'd1;
               end else if (HAS_GAP) begin
                  pix_n   = 4'h0;
                  gap_n   = GW'(GAP - 1);
                  state_n = ST_GAP;
               end else if (!fifo_empty) begin
                  start = 1'b1;
               end else begin
                  pix_n   = 4'h0;
                  state_n = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            pix_n = 4'h0;
            if (high_mid) begin
               if (gap_cnt != '0)    gap_n   = gap_cnt - GW'(1);
               else if (!fifo_empty) start   = 1'b1;
               else                  state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (start) begin
         pix_n     = load_frame[31:28];
         shifter_n = load_frame[27:0];
         nib_n     = 3'd0;
         fs_n      = 1'b1;
         state_n   = ST_SEND;
      end
      pop = start;
   end

   assign bus.phi2        = phi2_q;
   assign bus.pix         = pix_q;
   assign bus.busy        = busy_q;
   assign bus.frame_start = fs_q;
   assign bus.fifo_count  = count;
   assign bus.in_ready    = in_ready_q;
endmodule

// File: tb/tb_pix_bus_tx.sv
// Directed bench for pix_bus_tx: two instances (DIV=2/GAP=0/depth 16 and
// DIV=4/GAP=2/depth 4), each with a queue model and a behavioural PIX receiver.
module tb_pix_bus_tx;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pix_bus_tx_if #(.FIFO_DEPTH(16)) bus0 ();
   pix_bus_tx_if #(.FIFO_DEPTH(4))  bus1 ();

   pix_bus_tx #(.DIV(2), .FIFO_DEPTH(16), .GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   pix_bus_tx #(.DIV(4), .FIFO_DEPTH(4),  .GAP(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic        in_valid [2];
   logic [31:0] in_frame [2];
   logic        phi2_w [2];
   logic [3:0]  pix_w [2];
   logic        busy_w [2];
   logic        fs_w [2];
   logic        rdy_w [2];
   logic [31:0] cnt_w [2];

   assign bus0.in_valid = in_valid[0];
   assign bus0.in_frame = in_frame[0];
   assign bus1.in_valid = in_valid[1];
   assign bus1.in_frame = in_frame[1];
   assign phi2_w[0] = bus0.phi2;        assign phi2_w[1] = bus1.phi2;
   assign pix_w[0]  = bus0.pix;         assign pix_w[1]  = bus1.pix;
   assign busy_w[0] = bus0.busy;        assign busy_w[1] = bus1.busy;
   assign fs_w[0]   = bus0.frame_start; assign fs_w[1]   = bus1.frame_start;
   assign rdy_w[0]  = bus0.in_ready;    assign rdy_w[1]  = bus1.in_ready;
   assign cnt_w[0]  = 32'(bus0.fifo_count);
   assign cnt_w[1]  = 32'(bus1.fifo_count);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-instance queue model, scoreboard and receiver, all sampled on negedge clk
   for (genvar g = 0; g < 2; g++) begin : mon
      localparam int DEPTH = (g == 0) ? 16 : 4;
      logic [31:0] exp_q[$];
      int          starts[$];
      int          model_cnt = 0;
      logic        acc = 1'b0;
      logic        phi2_prev = 1'b1;
      logic        in_fr = 1'b0;
      int          nib_cnt = 0;
      logic [31:0] sh = '0;
      logic [31:0] last_rx = '0;
      int          fall_idx = 0;
      int          rx_count = 0;
      int          fs_count = 0;

      always @(negedge clk) begin
         if (!rst_n) begin
            model_cnt = 0;
            acc       = 1'b0;
            exp_q.delete();
            phi2_prev = 1'b1;
            in_fr     = 1'b0;
            nib_cnt   = 0;
         end else begin
            model_cnt = model_cnt + int'(acc) - int'(fs_w[g]);
            if (fs_w[g]) fs_count++;
            check($sformatf("fifo_count[%0d]", g), cnt_w[g], 32'(model_cnt));
            check($sformatf("in_ready[%0d]", g), 32'(rdy_w[g]), 32'(model_cnt < DEPTH));
            acc = in_valid[g] && (model_cnt < DEPTH);
            if (acc) exp_q.push_back(in_frame[g] | 32'h1000_0000);
            if (phi2_w[g] != phi2_prev) begin
               if (!phi2_w[g]) fall_idx++;
               if (!in_fr) begin
                  if (!phi2_w[g] && pix_w[g][0]) begin
                     in_fr   = 1'b1;
                     nib_cnt = 1;
                     sh      = {28'h0, pix_w[g]};
                     starts.push_back(fall_idx);
                  end
               end else begin
                  sh = {sh[27:0], pix_w[g]};
                  nib_cnt++;
                  if (nib_cnt == 8) begin
                     in_fr   = 1'b0;
                     last_rx = sh;
                     rx_count++;
                     check($sformatf("rx_expected[%0d]", g), 32'(exp_q.size() != 0), 32'd1);
                     if (exp_q.size() != 0)
                        check($sformatf("rx_frame[%0d]", g), sh, exp_q.pop_front());
                  end
               end
            end
            phi2_prev = phi2_w[g];
         end
      end
   end

   function automatic logic acc_of(input int g);
      return (g == 0) ? mon[0].acc : mon[1].acc;
   endfunction

   function automatic int rxc(input int g);
      return (g == 0) ? mon[0].rx_count : mon[1].rx_count;
   endfunction

   // Hold in_valid until the model says the frame was taken
   task automatic send(input int g, input logic [31:0] f);
      int   n = 0;
      logic ok;
      in_frame[g] = f;
      in_valid[g] = 1'b1;
      do begin
         @(posedge clk);
         n++;
      end while (!acc_of(g) && n < 400);
      ok = acc_of(g);
      #1;
      in_valid[g] = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rx(input int g, input int target, input int bound);
      int n = 0;
      while (rxc(g) < target && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("rx_wait[%0d]", g), 32'(rxc(g) >= target), 32'd1);
   endtask

   task automatic wait_pix(input int g, input int max_lat);
      int n = 0;
      while (pix_w[g] == 4'h0 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("latency[%0d]", g), 32'(n <= max_lat), 32'd1);
      check($sformatf("frame_start_hi[%0d]", g), 32'(fs_w[g]), 32'd1);
      check($sformatf("busy_sending[%0d]", g), 32'(busy_w[g]), 32'd1);
   endtask

   initial begin
      logic [31:0] fa;
      int          bad;
      int          n;
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      in_frame[0] = '0;   in_frame[1] = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         check("rst_phi2",  32'(phi2_w[g]), 32'd1);
         check("rst_pix",   32'(pix_w[g]),  32'd0);
         check("rst_busy",  32'(busy_w[g]), 32'd0);
         check("rst_fs",    32'(fs_w[g]),   32'd0);
         check("rst_count", cnt_w[g],       32'd0);
         check("rst_ready", 32'(rdy_w[g]),  32'd1);
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Single XREG frame, latency and decode
      send(0, 32'h4000_0001);
      wait_pix(0, 4);
      check("t1_nib0", 32'(pix_w[0]), 32'h5);
      @(posedge clk); #1;
      check("t1_fs_width", 32'(fs_w[0]), 32'd0);
      wait_rx(0, 1, 200);
      check("t1_type", 32'(mon[0].last_rx[31:29]), 32'd2);
      check("t1_data", 32'(mon[0].last_rx[27:0]), 32'h1);

      // Frame already carrying the framing bit; busy must clear within one phi2 period
      send(0, 32'h1234_5678);
      wait_rx(0, 2, 200);
      check("t2_frame", mon[0].last_rx, 32'h1234_5678);
      repeat (3) @(posedge clk);
      #1;
      check("t2_busy_drop", 32'(busy_w[0]), 32'd0);

      // 17 back-to-back pushes fill the queue, the 18th is held across a pop
      for (int i = 0; i < 17; i++) send(0, $urandom);
      check("t3_full_ready", 32'(rdy_w[0]), 32'd0);
      check("t3_full_count", cnt_w[0], 32'd16);
      send(0, $urandom);
      wait_rx(0, 20, 1200);
      bad = 0;
      if (mon[0].starts.size() >= 20) begin
         for (int i = 3; i < 20; i++)
            if (mon[0].starts[i] - mon[0].starts[i-1] != 4) bad++;
      end else begin
         bad = 99;
      end
      check("t3_contiguous", 32'(bad), 32'd0);

      // Reset while nibble 3 of a frame is on the wire, with a second frame queued
      fa = 32'hA5C3_96E1;
      send(0, fa);
      send(0, 32'h4765_4321);
      n = 0;
      while (!fs_w[0] && n < 100) begin @(posedge clk); #1; n++; end
      check("t5_fs_seen", 32'(fs_w[0]), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      check("t5_nib3", 32'(pix_w[0]), 32'(fa[19:16]));
      rst_n = 1'b0;
      #1;
      check("t5_rst_pix",   32'(pix_w[0]), 32'd0);
      check("t5_rst_phi2",  32'(phi2_w[0]), 32'd1);
      check("t5_rst_count", cnt_w[0], 32'd0);
      check("t5_rst_busy",  32'(busy_w[0]), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(0, 32'h0ABC_DEF0);
      wait_rx(0, 21, 200);
      check("t5_after", mon[0].last_rx, 32'h1ABC_DEF0);

      // GAP=2, DIV=4 instance: two queued frames separated by two idle periods
      send(1, 32'h4000_0001);
      send(1, 32'h2468_ACE0);
      wait_pix(1, 8);
      check("t6_nib0", 32'(pix_w[1]), 32'h5);
      wait_rx(1, 2, 400);
      check("t6_last", mon[1].last_rx, 32'h3468_ACE0);
      if (mon[1].starts.size() >= 2)
         check("t6_gap", 32'(mon[1].starts[1] - mon[1].starts[0]), 32'd6);
      else
         check("t6_gap_starts", 32'(mon[1].starts.size()), 32'd2);

      repeat (40) @(posedge clk);
      #1;
      check("end_q0",  32'(mon[0].exp_q.size()), 32'd0);
      check("end_q1",  32'(mon[1].exp_q.size()), 32'd0);
      check("end_fs0", 32'(mon[0].fs_count), 32'd22);
      check("end_fs1", 32'(mon[1].fs_count), 32'd2);
      check("end_rx0", 32'(mon[0].rx_count), 32'd21);
      check("end_idle_busy0", 32'(busy_w[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
